// File: rtl/td4_pkg.sv
// td4_pkg -- shared definitions for the TD4 instruction-cycle controller.
//   * sequencer state encoding
//   * default datapath widths and watchdog limit
//   * instruction field positions for the default 8-bit word {op[3:0], imm[3:0]}
package td4_pkg;

  localparam int PC_W_DEF    = 4;
  localparam int IMM_W_DEF   = 4;
  localparam int OP_W        = 4;
  localparam int TIMEOUT_DEF = 15;

  // Field positions inside the default 8-bit instruction word.
  localparam int OP_MSB  = 7;
  localparam int OP_LSB  = 4;
  localparam int IMM_MSB = 3;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/td4_pc.sv
// td4_pc -- program counter register.
// Synchronous active-low reset to 0; load has priority over increment;
// increment wraps modulo 2^PC_W.
// Ports:
//   clk_i       clock, rising edge
//   srst_n_i    synchronous active-low reset
//   load_i      load pc from load_val_i
//   inc_i       increment pc
//   load_val_i  jump target
//   pc_o        current pc (registered)
module td4_pc
  import td4_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic            clk_i,
  input  logic            srst_n_i,
  input  logic            load_i,
  input  logic            inc_i,
  input  logic [PC_W-1:0] load_val_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/td4_sequencer.sv
// td4_sequencer -- instruction-cycle controller for the 4-bit TD4 core.
// Fetches instructions from program ROM over req/ack, holds them in the IR,
// drives opcode/immediate to the decoder, owns PC and carry, and issues a
// one-cycle write strobe per executed instruction.
//
// Optional build macro SEQ_TIMEOUT_EN: adds a FETCH watchdog, the
// TIMEOUT_CYCLES parameter and the errout port. Without it FETCH waits
// for ack indefinitely.
//
// Ports:
//   clkin         clock, rising edge
//   n_resetin     synchronous active-low reset
//   runin         free-run enable
//   stepin        single-step request (sampled in IDLE)
//   rom_addrout   ROM address (= PC)
//   rom_reqout    fetch request
//   rom_ackin     ROM data valid
//   rom_datain    instruction word {op, imm}
//   op0out..op3out opcode bits from IR
//   immout        immediate from IR
//   cout          registered carry flag
//   carryin       adder carry-out of current instruction
//   jmp_nin       active-low PC load request
//   ld_strobeout  register write qualifier (one cycle in EXEC)
//   pcout         current PC
//   haltout       core halted
//   errout        ROM ack watchdog expired (SEQ_TIMEOUT_EN only)
module td4_sequencer
  import td4_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int IMM_W = IMM_W_DEF
`ifdef SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
`endif
) (
  input  logic                  clkin,
  input  logic                  n_resetin,
  input  logic                  runin,
  input  logic                  stepin,
  output logic [PC_W-1:0]       rom_addrout,
  output logic                  rom_reqout,
  input  logic                  rom_ackin,
  input  logic [OP_W+IMM_W-1:0] rom_datain,
  output logic                  op0out,
  output logic                  op1out,
  output logic                  op2out,
  output logic                  op3out,
  output logic [IMM_W-1:0]      immout,
  output logic                  cout,
  input  logic                  carryin,
  input  logic                  jmp_nin,
  output logic                  ld_strobeout,
  output logic [PC_W-1:0]       pcout,
  output logic                  haltout
`ifdef SEQ_TIMEOUT_EN
  ,
  output logic                  errout
`endif
);

  seq_state_e             state_q, state_d;
  logic [OP_W+IMM_W-1:0]  ir_q, ir_d;
  logic                   carry_q, carry_d;
  logic                   pc_load, pc_inc;
  logic [PC_W-1:0]        pc;
  logic [PC_W-1:0]        jump_target;
  logic                   self_jump;

  assign jump_target = ir_q[PC_W-1:0];
  // A taken jump whose target is the current PC can never make progress:
  // treat it as the program's halt instruction.
  assign self_jump   = !jmp_nin && (jump_target == pc);

`ifdef SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
  logic            wd_expired;

  // wd_q counts completed ack-less FETCH cycles; the current cycle is the
  // TIMEOUT_CYCLES-th one when wd_q has reached TIMEOUT_CYCLES-1.
  assign wd_expired = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wd_d = wd_q;
    if (state_q != ST_FETCH && state_d == ST_FETCH) begin
      wd_d = '0;
    end else if (state_q == ST_FETCH && !rom_ackin) begin
      wd_d = wd_q + WD_W'(1);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    carry_d = carry_q;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (runin || stepin) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // An ack in the timeout cycle still completes the fetch.
        if (rom_ackin) begin
          ir_d    = rom_datain;
          state_d = ST_EXEC;
        end
`ifdef SEQ_TIMEOUT_EN
        else if (wd_expired) begin
          state_d = ST_HALT;
          err_d   = 1'b1;
        end
`endif
      end
      ST_EXEC: begin
        carry_d = carryin;
        if (!jmp_nin) begin
          pc_load = 1'b1;
        end else begin
          pc_inc = 1'b1;
        end
        if (self_jump) begin
          state_d = ST_HALT;
        end else begin
          state_d = runin ? ST_FETCH : ST_IDLE;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clkin) begin
    if (!n_resetin) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
      carry_q <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      wd_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      carry_q <= carry_d;
`ifdef SEQ_TIMEOUT_EN
      wd_q    <= wd_d;
      err_q   <= err_d;
`endif
    end
  end

  td4_pc #(
    .PC_W(PC_W)
  ) u_pc (
    .clk_i      (clkin),
    .srst_n_i   (n_resetin),
    .load_i     (pc_load),
    .inc_i      (pc_inc),
    .load_val_i (jump_target),
    .pc_o       (pc)
  );

  // Control outputs are straight decodes of the state register.
  assign rom_reqout   = (state_q == ST_FETCH);
  assign ld_strobeout = (state_q == ST_EXEC);
  assign haltout      = (state_q == ST_HALT);
  assign rom_addrout  = pc;
  assign pcout        = pc;
  assign cout         = carry_q;
  assign immout       = ir_q[IMM_W-1:0];
  assign {op3out, op2out, op1out, op0out} = ir_q[IMM_W +: OP_W];
`ifdef SEQ_TIMEOUT_EN
  assign errout       = err_q;
`endif

endmodule
